// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
package irq_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned ACK_CNT_W  = 3;
    localparam int unsigned PC_RST_VAL = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        ACK     = 2'd2,
        HANDLER = 2'd3
    } state_e;

endpackage

// File: rtl/irq_seq_en_reg.sv
// Enable register cell with asynchronous active-high reset to a fixed value.
module irq_seq_en_reg #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/irq_seq.sv
// Interrupt entry/exit sequencer: takes irq at a retire boundary, saves epc,
// redirects fetch to the handler, acknowledges, and returns on eret.
module irq_seq
    import irq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned ACK_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] PC_handler,
    input  logic              retire,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              eret,
    input  logic              gie_set,
    input  logic              gie_val,
    output logic              iack,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              in_handler,
    output logic              gie
);

    localparam logic [ACK_CNT_W-1:0] ACK_CNT_INIT = ACK_CNT_W'(ACK_W - 1);
    localparam logic [ADDR_W-1:0]    PC_RST       = ADDR_W'(PC_RST_VAL);

    // Reject unsupported acknowledge lengths at elaboration.
    if (ACK_W < 1 || ACK_W > 8) begin : g_ack_w_check
        $error("irq_seq: ACK_W must be in 1..8");
    end

    state_e                 state_q, state_d;
    logic [ACK_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   iack_q, iack_d;
    logic                   redirect_q, redirect_d;
    logic                   in_handler_q, in_handler_d;
    logic                   gie_q, gie_d;
    logic [ADDR_W-1:0]      epc_q;
    logic [ADDR_W-1:0]      redirect_pc_q, redirect_pc_d;
    logic                   epc_en;
    logic                   redirect_pc_en;
    logic                   take_c;
    logic                   exit_c;

    // Entry needs a retire boundary; a redirect just issued blocks it so
    // redirect pulses never abut.
    assign take_c = irq && gie_q && retire &&
                    ((state_q == IDLE && !redirect_q) || state_q == PEND);
    assign exit_c = (state_q == HANDLER) && retire && eret;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        iack_d        = 1'b0;
        redirect_d    = 1'b0;
        in_handler_d  = in_handler_q;
        gie_d         = gie_q;
        redirect_pc_d = redirect_pc_q;
        redirect_pc_en = 1'b0;
        epc_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (gie_set) begin
                    gie_d = gie_val;
                end
                if (irq && gie_q && !take_c) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (gie_set) begin
                    gie_d = gie_val;
                end
                if (!irq || !gie_q) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (cnt_q == '0) begin
                    state_d = HANDLER;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    iack_d = 1'b1;
                end
            end
            HANDLER: begin
                if (exit_c) begin
                    state_d        = IDLE;
                    redirect_d     = 1'b1;
                    redirect_pc_d  = epc_q;
                    redirect_pc_en = 1'b1;
                    gie_d          = 1'b1;
                    in_handler_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture overrides the IDLE/PEND defaults, including any gie write.
        if (take_c) begin
            state_d        = ACK;
            cnt_d          = ACK_CNT_INIT;
            iack_d         = 1'b1;
            redirect_d     = 1'b1;
            redirect_pc_d  = PC_handler;
            redirect_pc_en = 1'b1;
            epc_en         = 1'b1;
            gie_d          = 1'b0;
            in_handler_d   = 1'b1;
        end
    end

    // State, counter and control-output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            iack_q       <= 1'b0;
            redirect_q   <= 1'b0;
            in_handler_q <= 1'b0;
            gie_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            iack_q       <= iack_d;
            redirect_q   <= redirect_d;
            in_handler_q <= in_handler_d;
            gie_q        <= gie_d;
        end
    end

    // Saved return PC; only an entry capture updates it.
    irq_seq_en_reg #(
        .W       (ADDR_W),
        .RST_VAL (PC_RST)
    ) u_epc_reg (
        .clk (clk),
        .rst (rst),
        .en  (epc_en),
        .d   (pc_next),
        .q   (epc_q)
    );

    // Fetch target: holds the handler address from capture, epc on exit.
    irq_seq_en_reg #(
        .W       (ADDR_W),
        .RST_VAL (PC_RST)
    ) u_redirect_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (redirect_pc_en),
        .d   (redirect_pc_d),
        .q   (redirect_pc_q)
    );

    assign iack        = iack_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign in_handler  = in_handler_q;
    assign gie         = gie_q;

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq with ACK_W=1 and ACK_W=4 instances.
module tb_irq_seq;

    logic        clk;
    logic        rst;
    logic        irq;
    logic [31:0] pc_handler;
    logic        retire;
    logic [31:0] pc_next;
    logic        eret;
    logic        gie_set;
    logic        gie_val;

    logic        o1_iack, o1_redirect, o1_in_handler, o1_gie;
    logic [31:0] o1_redirect_pc, o1_epc;
    logic        o4_iack, o4_redirect, o4_in_handler, o4_gie;
    logic [31:0] o4_redirect_pc, o4_epc;

    int checks = 0;
    int errors = 0;

    irq_seq #(.ADDR_W(32), .ACK_W(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .PC_handler  (pc_handler),
        .retire      (retire),
        .pc_next     (pc_next),
        .eret        (eret),
        .gie_set     (gie_set),
        .gie_val     (gie_val),
        .iack        (o1_iack),
        .redirect    (o1_redirect),
        .redirect_pc (o1_redirect_pc),
        .epc         (o1_epc),
        .in_handler  (o1_in_handler),
        .gie         (o1_gie)
    );

    irq_seq #(.ADDR_W(32), .ACK_W(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .PC_handler  (pc_handler),
        .retire      (retire),
        .pc_next     (pc_next),
        .eret        (eret),
        .gie_set     (gie_set),
        .gie_val     (gie_val),
        .iack        (o4_iack),
        .redirect    (o4_redirect),
        .redirect_pc (o4_redirect_pc),
        .epc         (o4_epc),
        .in_handler  (o4_in_handler),
        .gie         (o4_gie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq = 1'b0; pc_handler = '0; retire = 1'b0; pc_next = '0;
        eret = 1'b0; gie_set = 1'b0; gie_val = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++; if ({o1_iack, o1_redirect, o1_in_handler, o1_gie} !== 4'b0) begin errors++; $display("FAIL reset_ctl1 got=%b exp=0000", {o1_iack, o1_redirect, o1_in_handler, o1_gie}); end
        checks++; if ({o1_epc, o1_redirect_pc} !== 64'h0) begin errors++; $display("FAIL reset_pc1 got=%h exp=0", {o1_epc, o1_redirect_pc}); end
        checks++; if ({o4_iack, o4_redirect, o4_in_handler, o4_gie} !== 4'b0) begin errors++; $display("FAIL reset_ctl4 got=%b exp=0000", {o4_iack, o4_redirect, o4_in_handler, o4_gie}); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({o1_iack, o1_redirect, o1_gie} !== 3'b0) begin errors++; $display("FAIL reset_hold got=%b exp=000", {o1_iack, o1_redirect, o1_gie}); end
    endtask

    task automatic test_entry();
        gie_set = 1'b1; gie_val = 1'b1;
        tick();
        gie_set = 1'b0; gie_val = 1'b0;
        checks++; if (o1_gie !== 1'b1) begin errors++; $display("FAIL entry_gie_write got=%b exp=1", o1_gie); end
        irq = 1'b1; pc_handler = 32'h0000_0100; retire = 1'b1; pc_next = 32'h0000_2004;
        tick();
        irq = 1'b0; retire = 1'b0;
        checks++; if (o1_iack !== 1'b1) begin errors++; $display("FAIL entry_iack got=%b exp=1", o1_iack); end
        checks++; if (o1_redirect !== 1'b1) begin errors++; $display("FAIL entry_redirect got=%b exp=1", o1_redirect); end
        checks++; if (o1_redirect_pc !== 32'h100) begin errors++; $display("FAIL entry_redirect_pc got=%h exp=00000100", o1_redirect_pc); end
        checks++; if (o1_epc !== 32'h2004) begin errors++; $display("FAIL entry_epc got=%h exp=00002004", o1_epc); end
        checks++; if ({o1_gie, o1_in_handler} !== 2'b01) begin errors++; $display("FAIL entry_gie_inh got=%b exp=01", {o1_gie, o1_in_handler}); end
        tick();
        checks++; if ({o1_iack, o1_redirect, o1_in_handler} !== 3'b001) begin errors++; $display("FAIL entry_ack_end got=%b exp=001", {o1_iack, o1_redirect, o1_in_handler}); end
    endtask

    task automatic test_exit();
        retire = 1'b1; eret = 1'b1;
        tick();
        retire = 1'b0; eret = 1'b0;
        checks++; if (o1_redirect !== 1'b1) begin errors++; $display("FAIL exit_redirect got=%b exp=1", o1_redirect); end
        checks++; if (o1_redirect_pc !== 32'h2004) begin errors++; $display("FAIL exit_redirect_pc got=%h exp=00002004", o1_redirect_pc); end
        checks++; if ({o1_gie, o1_in_handler} !== 2'b10) begin errors++; $display("FAIL exit_gie_inh got=%b exp=10", {o1_gie, o1_in_handler}); end
        tick();
        checks++; if (o1_redirect !== 1'b0) begin errors++; $display("FAIL exit_redirect_pulse got=%b exp=0", o1_redirect); end
        tick();
        tick();
        retire = 1'b1; eret = 1'b1; pc_next = 32'h0000_7777;
        tick();
        retire = 1'b0; eret = 1'b0;
        checks++; if (o1_redirect !== 1'b0) begin errors++; $display("FAIL stray_eret_redirect got=%b exp=0", o1_redirect); end
        checks++; if (o1_epc !== 32'h2004) begin errors++; $display("FAIL stray_eret_epc got=%h exp=00002004", o1_epc); end
    endtask

    task automatic test_pending();
        irq = 1'b1; pc_handler = 32'h0000_0200; retire = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (o1_iack !== 1'b0) begin errors++; $display("FAIL pend_no_iack cyc=%0d got=%b exp=0", i, o1_iack); end
        end
        retire = 1'b1; pc_next = 32'h0000_3000;
        tick();
        irq = 1'b0; retire = 1'b0;
        checks++; if (o1_iack !== 1'b1) begin errors++; $display("FAIL pend_iack got=%b exp=1", o1_iack); end
        checks++; if (o1_epc !== 32'h3000) begin errors++; $display("FAIL pend_epc got=%h exp=00003000", o1_epc); end
        checks++; if (o1_redirect_pc !== 32'h200) begin errors++; $display("FAIL pend_redirect_pc got=%h exp=00000200", o1_redirect_pc); end
        tick();
        retire = 1'b1; eret = 1'b1;
        tick();
        retire = 1'b0; eret = 1'b0;
        checks++; if (o1_redirect_pc !== 32'h3000 || o1_redirect !== 1'b1) begin errors++; $display("FAIL pend_exit got=%b/%h exp=1/00003000", o1_redirect, o1_redirect_pc); end
        tick();
    endtask

    task automatic test_mask_no_nesting();
        gie_set = 1'b1; gie_val = 1'b0;
        tick();
        gie_set = 1'b0;
        checks++; if (o1_gie !== 1'b0) begin errors++; $display("FAIL mask_gie_clear got=%b exp=0", o1_gie); end
        irq = 1'b1; retire = 1'b1; pc_handler = 32'h0000_0500; pc_next = 32'h0000_4000;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({o1_iack, o1_redirect} !== 2'b00) begin errors++; $display("FAIL mask_no_entry cyc=%0d got=%b exp=00", i, {o1_iack, o1_redirect}); end
        end
        checks++; if (o1_epc !== 32'h3000) begin errors++; $display("FAIL mask_epc_kept got=%h exp=00003000", o1_epc); end
        gie_set = 1'b1; gie_val = 1'b1;
        tick();
        gie_set = 1'b0; gie_val = 1'b0;
        checks++; if ({o1_gie, o1_iack} !== 2'b10) begin errors++; $display("FAIL gie_write_delay got=%b exp=10", {o1_gie, o1_iack}); end
        tick();
        retire = 1'b0;
        checks++; if (o1_iack !== 1'b1 || o1_epc !== 32'h4000) begin errors++; $display("FAIL gie_late_entry got=%b/%h exp=1/00004000", o1_iack, o1_epc); end
        gie_set = 1'b1; gie_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({o1_gie, o1_iack, o1_redirect, o1_in_handler} !== 4'b0001) begin errors++; $display("FAIL no_nest cyc=%0d got=%b exp=0001", i, {o1_gie, o1_iack, o1_redirect, o1_in_handler}); end
        end
        gie_set = 1'b0; gie_val = 1'b0; irq = 1'b0;
        retire = 1'b1; eret = 1'b1;
        tick();
        retire = 1'b0; eret = 1'b0;
        checks++; if ({o1_gie, o1_redirect} !== 2'b11) begin errors++; $display("FAIL no_nest_exit got=%b exp=11", {o1_gie, o1_redirect}); end
        tick();
    endtask

    task automatic test_ack_w4();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gie_set = 1'b1; gie_val = 1'b1;
        tick();
        gie_set = 1'b0; gie_val = 1'b0;
        irq = 1'b1; pc_handler = 32'h0000_0400; retire = 1'b1; pc_next = 32'h0000_5000;
        tick();
        irq = 1'b0; retire = 1'b0;
        checks++; if ({o4_iack, o4_redirect} !== 2'b11 || o4_redirect_pc !== 32'h400) begin errors++; $display("FAIL w4_first got=%b/%h exp=11/00000400", {o4_iack, o4_redirect}, o4_redirect_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({o4_iack, o4_redirect} !== 2'b10) begin errors++; $display("FAIL w4_hold cyc=%0d got=%b exp=10", i, {o4_iack, o4_redirect}); end
        end
        tick();
        checks++; if ({o4_iack, o4_in_handler} !== 2'b01) begin errors++; $display("FAIL w4_end got=%b exp=01", {o4_iack, o4_in_handler}); end
        retire = 1'b1; eret = 1'b1; gie_set = 1'b1; gie_val = 1'b0;
        tick();
        retire = 1'b0; eret = 1'b0; gie_set = 1'b0;
        checks++; if ({o4_gie, o4_redirect, o4_in_handler} !== 3'b110) begin errors++; $display("FAIL w4_eret_wins got=%b exp=110", {o4_gie, o4_redirect, o4_in_handler}); end
        checks++; if (o4_redirect_pc !== 32'h5000) begin errors++; $display("FAIL w4_exit_pc got=%h exp=00005000", o4_redirect_pc); end
        tick();
        checks++; if ({o4_gie, o4_redirect} !== 2'b10) begin errors++; $display("FAIL w4_after_exit got=%b exp=10", {o4_gie, o4_redirect}); end
    endtask

    task automatic test_async_reset();
        irq = 1'b1; pc_handler = 32'h0000_0600; retire = 1'b1; pc_next = 32'h0000_6000;
        tick();
        irq = 1'b0; retire = 1'b0;
        checks++; if (o4_iack !== 1'b1 || o4_epc !== 32'h6000) begin errors++; $display("FAIL ar_entry got=%b/%h exp=1/00006000", o4_iack, o4_epc); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({o4_iack, o4_redirect, o4_in_handler, o4_gie} !== 4'b0) begin errors++; $display("FAIL ar_ctl got=%b exp=0000", {o4_iack, o4_redirect, o4_in_handler, o4_gie}); end
        checks++; if (o4_epc !== 32'h0 || o4_redirect_pc !== 32'h0) begin errors++; $display("FAIL ar_pc got=%h/%h exp=0/0", o4_epc, o4_redirect_pc); end
        #2;
        rst = 1'b0;
        irq = 1'b1; retire = 1'b1;
        tick();
        checks++; if ({o4_iack, o4_in_handler, o4_gie} !== 3'b000) begin errors++; $display("FAIL ar_idle got=%b exp=000", {o4_iack, o4_in_handler, o4_gie}); end
        tick();
        checks++; if ({o4_iack, o4_redirect} !== 2'b00) begin errors++; $display("FAIL ar_idle_hold got=%b exp=00", {o4_iack, o4_redirect}); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_pending();
        test_mask_no_nesting();
        test_ack_w4();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_seq.md
Name: irq_seq

Overview:
- CPU-side interrupt entry/exit sequencer, directly downstream of the interrupt controller.
- Consumes irq and PC_handler and waits for a precise instruction boundary.
- At that boundary it saves the return PC (epc), redirects fetch to the handler and returns iack to the controller.
- On a retired eret it redirects fetch back to epc and re-enables interrupts.

Parameters:
- ADDR_W, 32, width of all PC values.
- ACK_W, 1, iack pulse length in cycles; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  1  level request from the interrupt controller; held until acknowledged.
- PC_handler  in  ADDR_W  handler address, valid while irq=1.
- retire  in  1  an instruction retires this cycle; this is a safe boundary.
- pc_next  in  ADDR_W  PC of the next sequential instruction, valid with retire.
- eret  in  1  the retiring instruction is return-from-interrupt; qualified by retire.
- gie_set  in  1  software write strobe for the global interrupt enable.
- gie_val  in  1  value written by gie_set.
- iack  out  1  acknowledge to the interrupt controller.
- redirect  out  1  one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  out  ADDR_W  fetch target, valid with redirect.
- epc  out  ADDR_W  saved return PC.
- in_handler  out  1  high from entry until eret exit.
- gie  out  1  global interrupt enable.

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it forces the following, even mid-sequence:
  - state = IDLE
  - iack, redirect, in_handler, gie = 0
  - epc, redirect_pc = 0
  - ACK counter = 0
- All outputs are registered; each responds in the cycle after the triggering edge.
- States: IDLE, PEND, ACK, HANDLER.
- IDLE:
  - irq & gie & retire → capture epc <= pc_next and hdl <= PC_handler, go to ACK.
  - irq & gie & !retire → go to PEND.
  - Otherwise stay in IDLE.
- PEND:
  - retire → same capture as above, go to ACK.
  - irq deasserted or gie cleared → return to IDLE with no side effects.
- ACK:
  - iack = 1 for exactly ACK_W cycles.
  - In the first ACK cycle, redirect = 1 and redirect_pc = hdl.
  - Entering ACK forces gie <= 0 and sets in_handler <= 1.
  - After ACK_W cycles, go to HANDLER.
  - Retires during ACK are ignored; fetch is being redirected.
- HANDLER:
  - retire & eret → next cycle: redirect = 1, redirect_pc = epc, gie <= 1, in_handler <= 0; go to IDLE.
  - irq is ignored; no nesting.
- gie writes:
  - gie_set is honoured only in IDLE and PEND.
  - It is ignored in ACK and HANDLER.
  - If gie_set coincides with eret exit, the eret restore (gie=1) wins.
- eret outside HANDLER is ignored: no redirect, epc unchanged.
- irq and gie rising in the same cycle that gie_set writes 1: the new gie takes effect next cycle, so entry is earliest the following cycle.
- Retire in IDLE with irq=1 but gie=0: no entry; PC_handler is not sampled.
- epc holds its value until the next entry capture; it is not cleared on exit.
- redirect never asserts in two consecutive cycles.
- The minimum HANDLER occupancy is 1 cycle, i.e. eret in the first HANDLER cycle is legal.
- ACK counter is 3 bits and counts down from ACK_W-1. ACK_W outside 1..8 is a compile-time error via an elaboration check.

Decomposition:
- Shared package irq_pkg holds:
  - state enum {IDLE, PEND, ACK, HANDLER}
  - ADDR_W default localparam
  - reset-value constant for PC registers (0)
- One FSM plus counter; no sub-module is warranted.
- The epc and hdl holding registers use the codebase's existing enable-register cell.

Test Plan:
- Entry, ACK_W=1:
  - Stimulus: gie_set/gie_val=1, then irq=1, PC_handler=0x0000_0100, retire=1, pc_next=0x0000_2004.
  - Response: next cycle iack=1, redirect=1, redirect_pc=0x100, epc=0x2004, gie=0, in_handler=1; iack low the following cycle.
- Pending wait:
  - Stimulus: irq=1 with gie=1, retire held 0 for 5 cycles, then retire with pc_next=0x3000.
  - Response: state PEND, no iack until the cycle after retire; epc=0x3000.
- Exit:
  - Stimulus: in HANDLER, retire&eret.
  - Response: next cycle redirect=1, redirect_pc=epc (0x2004), gie=1, in_handler=0.
  - Stimulus: a second eret 3 cycles later.
  - Response: no redirect.
- Masking and no nesting:
  - Stimulus: gie=0 with irq=1 and retire every cycle for 10 cycles.
  - Response: no iack, no redirect.
  - Stimulus: in HANDLER, irq stays 1 and gie_set/gie_val=1.
  - Response: gie stays 0, no re-entry.
- ACK_W=4 and simultaneous events:
  - Response: iack high exactly 4 cycles, redirect only in the first.
  - Stimulus: gie_set/gie_val=0 coincident with eret.
  - Response: gie=1 after exit.
- Async reset mid-ACK:
  - Stimulus: rst pulse in the 2nd ACK cycle, not clock-aligned.
  - Response: iack, redirect, in_handler, gie drop to 0 immediately; epc=0; state IDLE after release.
